// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package imem_uart_loader_pkg;

  // Receive FSM states of the UART byte receiver
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // 100 MHz clock, 115200 baud
  localparam int DEFAULT_CLK_DIV = 868;
  // 1024 words = 4 KB of instruction memory
  localparam int DEFAULT_IMEM_AW = 10;
  // Width of one byte lane in the assembled word
  localparam int BYTE_W = 8;
  // Number of byte lanes per 32-bit word and width of the lane counter
  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  // Zero-extend the bytes gathered so far into a full word for a flush write
  function automatic logic [31:0] partial_word(input logic [23:0] asm,
                                               input logic [LANE_W-1:0] lanes);
    logic [31:0] word;
    case (lanes)
      2'd1:    word = {24'h000000, asm[7:0]};
      2'd2:    word = {16'h0000, asm[15:0]};
      2'd3:    word = {8'h00, asm[23:0]};
      default: word = 32'h00000000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-RAM write port driven by the loader.
interface imem_uart_loader_if #(
  parameter int AW = 10
) ();
  logic          imem_wr;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (output imem_wr, output imem_addr, output imem_wdata);
  modport slave  (input  imem_wr, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer plus mid-bit sampling FSM.
// Outputs are single-cycle pulses registered at the stop-bit sample.
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd_i,
  input  logic              abort_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_valid_o,
  output logic              frame_error_o
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  rx_state_e         state_q;
  logic              sync1_q;
  logic              sync2_q;
  logic [1:0]        fill_q;     // becomes 2'b11 once sync2_q holds a real line sample
  logic              armed_q;    // line seen high in IDLE; a low now is a true falling edge
  logic [CW-1:0]     cnt_q;
  logic [2:0]        bit_q;
  logic [BYTE_W-1:0] shift_q;
  logic [BYTE_W-1:0] byte_q;
  logic              valid_q;
  logic              ferr_q;

  // Synchronizer, arming and frame FSM in one registered process
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (abort_i) begin
        // Abandon any frame; wait for the line to be seen high again
        state_q <= RX_IDLE;
        armed_q <= 1'b0;
        cnt_q   <= '0;
        bit_q   <= 3'd0;
      end else begin
        case (state_q)
          RX_IDLE: begin
            cnt_q <= '0;
            bit_q <= 3'd0;
            if (armed_q && !sync2_q) begin
              state_q <= RX_START;
              armed_q <= 1'b0;
            end else if (fill_q[1] && sync2_q) begin
              armed_q <= 1'b1;
            end else begin
              armed_q <= armed_q;
            end
          end
          RX_START: begin
            if (cnt_q == HALF_LAST) begin
              cnt_q   <= '0;
              state_q <= sync2_q ? RX_IDLE : RX_DATA;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q   <= '0;
              shift_q <= {sync2_q, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                state_q <= RX_STOP;
              end else begin
                state_q <= RX_DATA;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q   <= '0;
              state_q <= RX_IDLE;
              if (sync2_q) begin
                valid_q <= 1'b1;
                byte_q  <= shift_q;
              end else begin
                ferr_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign byte_o        = byte_q;
  assign byte_valid_o  = valid_q;
  assign frame_error_o = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Loads 32-bit instruction words received over UART into the instruction RAM
// while load_imem is high, holding the core in reset for the whole session.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int IMEM_AW = DEFAULT_IMEM_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_imem,
  input  logic                uart_rxd,
  imem_uart_loader_if.master  imem_bus,
  output logic                core_hold,
  output logic                load_done,
  output logic                frame_err,
  output logic [IMEM_AW:0]    words_loaded
);

  localparam logic [IMEM_AW-1:0] ADDR_MAX = {IMEM_AW{1'b1}};

  logic [BYTE_W-1:0] rx_byte_s;
  logic              rx_valid_s;
  logic              rx_ferr_s;
  logic              rise_s;
  logic              fall_s;
  logic              full_s;
  logic              accept_s;

  logic               load_prev_q,  load_prev_d;
  logic               active_q,     active_d;
  logic               flush_pend_q, flush_pend_d;
  logic               clear_pend_q, clear_pend_d;
  logic [LANE_W-1:0]  lane_q,       lane_d;
  logic [23:0]        asm_q,        asm_d;
  logic               imem_wr_q,    imem_wr_d;
  logic [IMEM_AW-1:0] imem_addr_q,  imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic [IMEM_AW:0]   words_q,      words_d;
  logic               load_done_q,  load_done_d;
  logic               frame_err_q,  frame_err_d;
  logic               core_hold_q,  core_hold_d;

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk           (clk),
    .reset         (reset),
    .rxd_i         (uart_rxd),
    .abort_i       (fall_s),
    .byte_o        (rx_byte_s),
    .byte_valid_o  (rx_valid_s),
    .frame_error_o (rx_ferr_s)
  );

  assign rise_s   = load_imem & ~load_prev_q;
  assign fall_s   = ~load_imem & load_prev_q;
  assign full_s   = words_q[IMEM_AW];
  assign accept_s = rx_valid_s & load_imem & active_q & ~full_s & ~flush_pend_q & ~clear_pend_q;

  // Session control, word assembly and write-strobe generation
  always_comb begin
    load_prev_d  = load_imem;
    active_d     = active_q;
    flush_pend_d = flush_pend_q;
    clear_pend_d = clear_pend_q;
    lane_d       = lane_q;
    asm_d        = asm_q;
    imem_wr_d    = 1'b0;
    imem_wdata_d = imem_wdata_q;
    load_done_d  = load_done_q;
    core_hold_d  = load_imem;

    // A write issued last cycle advances the address (saturating) and the count
    if (imem_wr_q) begin
      words_d = words_q + (IMEM_AW+1)'(1);
      if (imem_addr_q != ADDR_MAX) begin
        imem_addr_d = imem_addr_q + IMEM_AW'(1);
      end else begin
        imem_addr_d = imem_addr_q;
      end
    end else begin
      words_d     = words_q;
      imem_addr_d = imem_addr_q;
    end

    if (rx_ferr_s && load_imem && active_q) begin
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = frame_err_q;
    end

    if (flush_pend_q) begin
      // Flush write is on the bus this cycle; finish the session
      flush_pend_d = 1'b0;
      load_done_d  = 1'b1;
      core_hold_d  = load_imem;
      clear_pend_d = rise_s;
    end else if (clear_pend_q || rise_s) begin
      clear_pend_d = 1'b0;
      active_d     = 1'b1;
      imem_addr_d  = {IMEM_AW{1'b0}};
      words_d      = {(IMEM_AW+1){1'b0}};
      lane_d       = 2'd0;
      load_done_d  = 1'b0;
      frame_err_d  = 1'b0;
      core_hold_d  = load_imem;
    end else if (fall_s) begin
      active_d = 1'b0;
      lane_d   = 2'd0;
      if (active_q && (lane_q != 2'd0) && !full_s) begin
        imem_wr_d    = 1'b1;
        imem_wdata_d = partial_word(asm_q, lane_q);
        flush_pend_d = 1'b1;
        core_hold_d  = 1'b1;
      end else if (active_q) begin
        load_done_d = 1'b1;
        core_hold_d = 1'b0;
      end else begin
        core_hold_d = 1'b0;
      end
    end else if (accept_s) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    asm_d[7:0]   = rx_byte_s;
        2'd1:    asm_d[15:8]  = rx_byte_s;
        2'd2:    asm_d[23:16] = rx_byte_s;
        default: begin
          imem_wr_d    = 1'b1;
          imem_wdata_d = {rx_byte_s, asm_q};
        end
      endcase
    end else begin
      core_hold_d = load_imem;
    end
  end

  // State registers with synchronous reset; a reset aborts any session
  always_ff @(posedge clk) begin
    if (reset) begin
      load_prev_q  <= 1'b1;
      active_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      clear_pend_q <= 1'b0;
      lane_q       <= 2'd0;
      asm_q        <= 24'h000000;
      imem_wr_q    <= 1'b0;
      imem_addr_q  <= {IMEM_AW{1'b0}};
      imem_wdata_q <= 32'h00000000;
      words_q      <= {(IMEM_AW+1){1'b0}};
      load_done_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      core_hold_q  <= 1'b0;
    end else begin
      load_prev_q  <= load_prev_d;
      active_q     <= active_d;
      flush_pend_q <= flush_pend_d;
      clear_pend_q <= clear_pend_d;
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      imem_wr_q    <= imem_wr_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      words_q      <= words_d;
      load_done_q  <= load_done_d;
      frame_err_q  <= frame_err_d;
      core_hold_q  <= core_hold_d;
    end
  end

  assign imem_bus.imem_wr    = imem_wr_q;
  assign imem_bus.imem_addr  = imem_addr_q;
  assign imem_bus.imem_wdata = imem_wdata_q;
  assign core_hold           = core_hold_q;
  assign load_done           = load_done_q;
  assign frame_err           = frame_err_q;
  assign words_loaded        = words_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed + random-byte bench for imem_uart_loader with a queue-based
// reference model of loader sessions.
module tb_imem_uart_loader;

  localparam int CLK_DIV = 16;
  localparam int AW      = 2;
  localparam int CAP     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_imem;
  logic        uart_rxd;
  logic        core_hold;
  logic        load_done;
  logic        frame_err;
  logic [AW:0] words_loaded;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_wr[$];
  logic [63:0] act_wr[$];
  logic [7:0]  lane_b[$];
  int          exp_words;
  bit          m_active;

  imem_uart_loader_if #(.AW(AW)) bus ();

  imem_uart_loader #(.CLK_DIV(CLK_DIV), .IMEM_AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_imem    (load_imem),
    .uart_rxd     (uart_rxd),
    .imem_bus     (bus),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .frame_err    (frame_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Record every write cycle seen on the RAM port
  always @(negedge clk) begin
    if (bus.imem_wr === 1'b1) act_wr.push_back({32'(bus.imem_addr), bus.imem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a session collects bytes; every 4 bytes form a
  // little-endian word written at the next word index until memory is full.
  task automatic model_start();
    m_active = 1'b1; exp_words = 0; lane_b.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_active && exp_words < CAP) begin
      lane_b.push_back(b);
      if (lane_b.size() == 4) begin
        exp_wr.push_back({32'(exp_words), lane_b[3], lane_b[2], lane_b[1], lane_b[0]});
        exp_words++;
        lane_b.delete();
      end
    end
  endtask

  task automatic model_stop();
    logic [31:0] w;
    w = 32'h0;
    if (m_active && lane_b.size() > 0 && exp_words < CAP) begin
      for (int i = 0; i < lane_b.size(); i++) w[8*i +: 8] = lane_b[i];
      exp_wr.push_back({32'(exp_words), w});
      exp_words++;
    end
    lane_b.delete();
    m_active = 1'b0;
  endtask

  task automatic model_abort();
    m_active = 1'b0; exp_words = 0; lane_b.delete();
  endtask

  task automatic check_state(input string tag);
    int ea;
    ea = (exp_words < CAP) ? exp_words : CAP - 1;
    check({tag, ".words"}, 64'(words_loaded), 64'(exp_words));
    check({tag, ".addr"}, 64'(bus.imem_addr), 64'(ea));
    check({tag, ".nwr"}, 64'(act_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
      check($sformatf("%s.wr%0d", tag, i), act_wr[i], exp_wr[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".wr"},    64'(bus.imem_wr),    64'd0);
    check({tag, ".addr"},  64'(bus.imem_addr),  64'd0);
    check({tag, ".wdata"}, 64'(bus.imem_wdata), 64'd0);
    check({tag, ".words"}, 64'(words_loaded),   64'd0);
    check({tag, ".done"},  64'(load_done),      64'd0);
    check({tag, ".ferr"},  64'(frame_err),      64'd0);
    check({tag, ".hold"},  64'(core_hold),      64'd0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk); uart_rxd = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (CLK_DIV) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1);
    model_byte(b);
  endtask

  initial begin
    logic [7:0] b;
    reset = 1'b1; load_imem = 1'b0; uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Two whole words
    load_imem = 1'b1; model_start();
    repeat (2) @(negedge clk);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
    check_state("two_words");
    check("two_words.w0", act_wr[0], 64'h0000_0000_0000_0013);
    check("two_words.w1", act_wr[1], 64'h0000_0001_0000_006F);
    check("two_words.hold", 64'(core_hold), 64'd1);

    // End with no partial word: done on the next edge
    load_imem = 1'b0; model_stop();
    @(posedge clk); #1;
    check("end0.done", 64'(load_done), 64'd1);
    check("end0.hold", 64'(core_hold), 64'd0);

    // Partial-word flush
    @(negedge clk); load_imem = 1'b1; model_start();
    @(posedge clk); #1;
    check("start.done", 64'(load_done), 64'd0);
    check("start.words", 64'(words_loaded), 64'd0);
    send(8'hAA); send(8'hBB);
    load_imem = 1'b0; model_stop();
    @(posedge clk); #1;
    check("flush.wr", 64'(bus.imem_wr), 64'd1);
    check("flush.addr", 64'(bus.imem_addr), 64'd0);
    check("flush.wdata", 64'(bus.imem_wdata), 64'h0000BBAA);
    check("flush.hold", 64'(core_hold), 64'd1);
    check("flush.done0", 64'(load_done), 64'd0);
    @(posedge clk); #1;
    check("flush.wr_end", 64'(bus.imem_wr), 64'd0);
    check("flush.done1", 64'(load_done), 64'd1);
    check("flush.hold_end", 64'(core_hold), 64'd0);
    check_state("flush");

    // Bad stop bit between good bytes
    @(negedge clk); load_imem = 1'b1; model_start();
    repeat (2) @(negedge clk);
    b = 8'($urandom); send(b);
    send_frame(8'h55, 1'b0);
    check("ferr.set", 64'(frame_err), 64'd1);
    check_state("ferr.nowrite");
    for (int i = 0; i < 3; i++) begin b = 8'($urandom); send(b); end
    check_state("ferr.recover");
    check("ferr.sticky", 64'(frame_err), 64'd1);

    // Fill memory and keep sending
    load_imem = 1'b0; model_stop();
    repeat (3) @(negedge clk);
    load_imem = 1'b1; model_start();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin b = 8'($urandom); send(b); end
    check_state("full");
    check("full.addr3", 64'(bus.imem_addr), 64'd3);
    load_imem = 1'b0; model_stop();
    @(posedge clk); #1;
    check("full.noflush", 64'(bus.imem_wr), 64'd0);
    check("full.done", 64'(load_done), 64'd1);

    // Re-assert during a flush
    @(negedge clk); load_imem = 1'b1; model_start();
    repeat (2) @(negedge clk);
    b = 8'($urandom); send(b);
    load_imem = 1'b0; model_stop();
    @(posedge clk); #1;
    check("reassert.flush", 64'(bus.imem_wr), 64'd1);
    @(negedge clk); load_imem = 1'b1;
    @(posedge clk); #1;
    check("reassert.done", 64'(load_done), 64'd1);
    @(posedge clk); #1;
    check("reassert.cleared", 64'(load_done), 64'd0);
    model_start();
    check_state("reassert");

    // Frame in progress when load_imem drops is abandoned
    b = 8'($urandom); send(b);
    fork
      send_frame(8'($urandom), 1'b1);
      begin
        repeat (60) @(negedge clk);
        load_imem = 1'b0; model_stop();
      end
    join
    repeat (200) @(negedge clk);
    check_state("abandon");
    check("abandon.done", 64'(load_done), 64'd1);

    // Reset in the middle of the third word
    load_imem = 1'b1; model_start();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin b = 8'($urandom); send(b); end
    fork
      send_frame(8'($urandom), 1'b1);
      begin
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("midrst");
      end
    join
    check_reset_vals("midrst.held");
    check("midrst.nwr", 64'(act_wr.size()), 64'(exp_wr.size()));
    @(negedge clk); reset = 1'b0; model_abort();
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1);
    check_state("midrst.inactive");
    load_imem = 1'b0;
    @(posedge clk); #1;
    check("midrst.nodone", 64'(load_done), 64'd0);
    check("midrst.noflush", 64'(bus.imem_wr), 64'd0);

    // Line held low from reset, then a short glitch
    @(negedge clk); reset = 1'b1; uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    load_imem = 1'b1; model_start();
    repeat (300) @(negedge clk);
    check_state("low");
    check("low.ferr", 64'(frame_err), 64'd0);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (200) @(negedge clk);
    check_state("glitch");
    check("glitch.ferr", 64'(frame_err), 64'd0);
    for (int i = 0; i < 4; i++) begin b = 8'($urandom); send(b); end
    check_state("after_glitch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
